pipeline_stall_sequencer: RTL and testbench

//  Sequences stall, bubble and flush controls for the 5-stage MIPS pipeline; registered successor to
//  the combinational hazard check. Covers load-use stalls, ID-stage branch/JR operand stalls
//  (1 or 2 cycles), fixed-latency mul/div freezes and control-transfer flushes. Sits beside the
//  ID stage; drives PC, IF/ID, ID/EX and EX/MEM write/bubble enables.

---
 rtl/pipeline_stall_sequencer_pkg.sv | 28 ++
 rtl/pipeline_stall_sequencer_if.sv | 51 +++++
 rtl/hazard_down_counter.sv | 29 ++
 rtl/pipeline_stall_sequencer.sv | 147 ++++++++++++++
 tb/tb_pipeline_stall_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_stall_sequencer_pkg.sv
// Shared encodings and helpers for the pipeline stall sequencer.
// Holds the FSM states, register-file constants and the operand match rule.
package hazard_pkg;

    localparam int REG_W = 5;
    localparam int CTR_W = 4;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_MULDIV = 2'd2
    } seq_state_t;

    // R0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(
        input logic [REG_W-1:0] dst,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             use_rs,
        input logic             use_rt
    );
        return (dst != REG_ZERO) &&
               ((use_rs && rs == dst) ||
                (use_rt && rt == dst));
    endfunction

endpackage

// File: rtl/pipeline_stall_sequencer_if.sv
// Hazard inputs from the ID/EX/MEM stages and the pipeline enables
// the sequencer drives back; slave is the sequencer side.
interface pipeline_stall_sequencer_if #(
    parameter int CNT_W = 16
);
    import hazard_pkg::*;

    logic [REG_W-1:0] Rs_ID;
    logic [REG_W-1:0] Rt_ID;
    logic             UsesRs_ID;
    logic             UsesRt_ID;
    logic             IsBranch_ID;
    logic             Jump_ID;
    logic             BranchTaken_ID;
    logic [REG_W-1:0] RegDst_EX;
    logic             RegWrite_EX;
    logic             MemRead_EX;
    logic [REG_W-1:0] RegDst_MEM;
    logic             MemRead_MEM;
    logic             MulDivStart_EX;

    logic             PCWrite;
    logic             IFID_Write;
    logic             IF_Flush;
    logic             IDEX_Bubble;
    logic             IDEX_Write;
    logic             EXMEM_Bubble;
    logic             Busy;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID,
        output IsBranch_ID, Jump_ID, BranchTaken_ID,
        output RegDst_EX, RegWrite_EX, MemRead_EX,
        output RegDst_MEM, MemRead_MEM, MulDivStart_EX,
        input  PCWrite, IFID_Write, IF_Flush,
        input  IDEX_Bubble, IDEX_Write, EXMEM_Bubble,
        input  Busy, StallCount
    );

    modport slave (
        input  Rs_ID, Rt_ID, UsesRs_ID, UsesRt_ID,
        input  IsBranch_ID, Jump_ID, BranchTaken_ID,
        input  RegDst_EX, RegWrite_EX, MemRead_EX,
        input  RegDst_MEM, MemRead_MEM, MulDivStart_EX,
        output PCWrite, IFID_Write, IF_Flush,
        output IDEX_Bubble, IDEX_Write, EXMEM_Bubble,
        output Busy, StallCount
    );

endinterface

// File: rtl/hazard_down_counter.sv
// Loadable down counter holding the cycles left in a stall or freeze.
// last flags the final cycle, zero flags an idle counter.
module hazard_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         last
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Registered stall/bubble/flush sequencer for the 5-stage pipeline:
// load-use and branch operand stalls, mul/div freezes, redirect flushes.
module pipeline_stall_sequencer
    import hazard_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input logic Clk,
    input logic Rst_n,
    pipeline_stall_sequencer_if.slave bus
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] stall_cnt;

    logic             ctr_load;
    logic [CTR_W-1:0] ctr_val;
    logic             ctr_dec;
    logic [CTR_W-1:0] ctr;
    logic             ctr_zero;
    logic             ctr_last;

    logic match_ex;
    logic match_mem;
    logic haz_two;
    logic haz_one;
    logic redirect;

    logic pc_write;
    logic ifid_write;
    logic if_flush;
    logic idex_bubble;
    logic idex_write;
    logic exmem_bubble;

    hazard_down_counter #(.W(CTR_W)) u_ctr (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (ctr_load),
        .load_val (ctr_val),
        .dec      (ctr_dec),
        .count    (ctr),
        .zero     (ctr_zero),
        .last     (ctr_last)
    );

    assign match_ex = reg_match(
        bus.RegDst_EX, bus.Rs_ID, bus.Rt_ID,
        bus.UsesRs_ID, bus.UsesRt_ID);
    assign match_mem = reg_match(
        bus.RegDst_MEM, bus.Rs_ID, bus.Rt_ID,
        bus.UsesRs_ID, bus.UsesRt_ID);

    assign haz_two = bus.IsBranch_ID &&
                     bus.MemRead_EX && match_ex;
    assign haz_one =
        (bus.MemRead_EX && match_ex) ||
        (bus.IsBranch_ID && bus.RegWrite_EX && match_ex) ||
        (bus.IsBranch_ID && bus.MemRead_MEM && match_mem);
    assign redirect = bus.Jump_ID ||
                      (bus.IsBranch_ID && bus.BranchTaken_ID);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (!pc_write && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next   = state;
        ctr_load     = 1'b0;
        ctr_val      = '0;
        ctr_dec      = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        if_flush     = 1'b0;
        idex_bubble  = 1'b0;
        idex_write   = 1'b1;
        exmem_bubble = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (bus.MulDivStart_EX) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exmem_bubble = 1'b1;
                    ctr_load     = 1'b1;
                    ctr_val      = CTR_W'(MULDIV_LAT - 1);
                    state_next   = ST_MULDIV;
                end else if (haz_two) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    ctr_load    = 1'b1;
                    ctr_val     = CTR_W'(1);
                    state_next  = ST_STALL;
                end else if (haz_one) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (redirect) begin
                    if_flush = 1'b1;
                end
            end
            ST_STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                ctr_dec     = 1'b1;
                if (ctr_last || ctr_zero) begin
                    state_next = ST_RUN;
                end
            end
            ST_MULDIV: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                ctr_dec      = 1'b1;
                if (ctr_last || ctr_zero) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    assign bus.PCWrite      = pc_write;
    assign bus.IFID_Write   = ifid_write;
    assign bus.IF_Flush     = if_flush;
    assign bus.IDEX_Bubble  = idex_bubble;
    assign bus.IDEX_Write   = idex_write;
    assign bus.EXMEM_Bubble = exmem_bubble;
    assign bus.Busy         = (state != ST_RUN);
    assign bus.StallCount   = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Bench for pipeline_stall_sequencer: a 16-bit and a 4-bit counter build
// share one stimulus stream and are checked against a cycle model.
module tb_pipeline_stall_sequencer;

    localparam int LAT = 4;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [4:0] rs, rt, rd_ex, rd_mem;
    logic use_rs, use_rt, is_br, jump, taken;
    logic regwr_ex, memrd_ex, memrd_mem, mds;

    int checks = 0;
    int errors = 0;

    // Model: cycles of freeze/stall still owed, and stall-cycle totals.
    int frz = 0;
    int stl = 0;
    int cnt_a = 0;
    int cnt_b = 0;

    pipeline_stall_sequencer_if #(.CNT_W(16)) bus_a ();
    pipeline_stall_sequencer_if #(.CNT_W(4))  bus_b ();

    assign bus_a.Rs_ID = rs;
    assign bus_a.Rt_ID = rt;
    assign bus_a.UsesRs_ID = use_rs;
    assign bus_a.UsesRt_ID = use_rt;
    assign bus_a.IsBranch_ID = is_br;
    assign bus_a.Jump_ID = jump;
    assign bus_a.BranchTaken_ID = taken;
    assign bus_a.RegDst_EX = rd_ex;
    assign bus_a.RegWrite_EX = regwr_ex;
    assign bus_a.MemRead_EX = memrd_ex;
    assign bus_a.RegDst_MEM = rd_mem;
    assign bus_a.MemRead_MEM = memrd_mem;
    assign bus_a.MulDivStart_EX = mds;

    assign bus_b.Rs_ID = rs;
    assign bus_b.Rt_ID = rt;
    assign bus_b.UsesRs_ID = use_rs;
    assign bus_b.UsesRt_ID = use_rt;
    assign bus_b.IsBranch_ID = is_br;
    assign bus_b.Jump_ID = jump;
    assign bus_b.BranchTaken_ID = taken;
    assign bus_b.RegDst_EX = rd_ex;
    assign bus_b.RegWrite_EX = regwr_ex;
    assign bus_b.MemRead_EX = memrd_ex;
    assign bus_b.RegDst_MEM = rd_mem;
    assign bus_b.MemRead_MEM = memrd_mem;
    assign bus_b.MulDivStart_EX = mds;

    pipeline_stall_sequencer #(
        .MULDIV_LAT (LAT),
        .CNT_W      (16)
    ) dut_a (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    pipeline_stall_sequencer #(
        .MULDIV_LAT (LAT),
        .CNT_W      (4)
    ) dut_b (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic bit m(input logic [4:0] d);
        return d != 0 &&
               ((use_rs && rs == d) || (use_rt && rt == d));
    endfunction

    task automatic idle();
        rs = 0; rt = 0; rd_ex = 0; rd_mem = 0;
        use_rs = 0; use_rt = 0; is_br = 0;
        jump = 0; taken = 0; regwr_ex = 0;
        memrd_ex = 0; memrd_mem = 0; mds = 0;
    endtask

    // One clock: check at the falling edge, advance model at the rising one.
    task automatic step();
        bit pc, ifid, fl, bub, idw, exb, busy;
        @(negedge clk);
        if (rst_n) begin
            pc = 1; ifid = 1; fl = 0; bub = 0;
            idw = 1; exb = 0;
            busy = (frz > 0) || (stl > 0);
            if (frz > 0 || (stl == 0 && mds)) begin
                pc = 0; ifid = 0; idw = 0; exb = 1;
                frz = (frz > 0) ? frz - 1 : LAT - 1;
            end else if (stl > 0) begin
                pc = 0; ifid = 0; bub = 1;
                stl--;
            end else if (is_br && memrd_ex && m(rd_ex)) begin
                pc = 0; ifid = 0; bub = 1;
                stl = 1;
            end else if ((memrd_ex && m(rd_ex)) ||
                         (is_br && regwr_ex && m(rd_ex)) ||
                         (is_br && memrd_mem && m(rd_mem))) begin
                pc = 0; ifid = 0; bub = 1;
            end else if (jump || (is_br && taken)) begin
                fl = 1;
            end
            chk("pcwrite_a", bus_a.PCWrite, pc);
            chk("ifid_a", bus_a.IFID_Write, ifid);
            chk("flush_a", bus_a.IF_Flush, fl);
            chk("idexbub_a", bus_a.IDEX_Bubble, bub);
            chk("idexw_a", bus_a.IDEX_Write, idw);
            chk("exmembub_a", bus_a.EXMEM_Bubble, exb);
            chk("busy_a", bus_a.Busy, busy);
            chk("cnt_a", bus_a.StallCount, cnt_a);
            chk("pcwrite_b", bus_b.PCWrite, pc);
            chk("busy_b", bus_b.Busy, busy);
            chk("cnt_b", bus_b.StallCount, cnt_b);
            if (!pc) begin
                cnt_a = (cnt_a < MAX_A) ? cnt_a + 1 : MAX_A;
                cnt_b = (cnt_b < MAX_B) ? cnt_b + 1 : MAX_B;
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            frz = 0; stl = 0; cnt_a = 0; cnt_b = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        do_reset();
        #2;
        chk("rst_pcwrite", bus_a.PCWrite, 1);
        chk("rst_busy", bus_a.Busy, 0);
        chk("rst_cnt", bus_a.StallCount, 0);
        step();

        // Load-use on Rs
        memrd_ex = 1; rd_ex = 8; use_rs = 1; rs = 8;
        step();
        idle();
        #2;
        chk("t1_cnt", bus_a.StallCount, 1);
        step();

        // Load feeding a branch compare: two stall cycles, then taken
        memrd_ex = 1; rd_ex = 9; is_br = 1; use_rt = 1; rt = 9;
        step();
        #2;
        chk("t2_busy", bus_a.Busy, 1);
        step();
        idle();
        is_br = 1; taken = 1;
        #2;
        chk("t2_flush", bus_a.IF_Flush, 1);
        step();
        idle();

        // R0 never stalls
        memrd_ex = 1; rd_ex = 0; use_rs = 1; rs = 0;
        #2;
        chk("t3_pcwrite", bus_a.PCWrite, 1);
        step();

        // Mul/div freeze with a concurrent load-use pattern
        idle();
        mds = 1;
        step();
        mds = 0; memrd_ex = 1; rd_ex = 5; use_rs = 1; rs = 5;
        repeat (3) step();
        idle();
        #2;
        chk("t4_exit", bus_a.PCWrite, 1);
        step();

        // Reset during freeze cycle 2
        mds = 1;
        step();
        mds = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        #2;
        chk("t5_pcwrite", bus_a.PCWrite, 1);
        chk("t5_busy", bus_a.Busy, 0);
        chk("t5_cnt", bus_a.StallCount, 0);
        step();

        // Counter saturation on the narrow build
        do_reset();
        memrd_ex = 1; rd_ex = 3; use_rt = 1; rt = 3;
        repeat (20) step();
        idle();
        #2;
        chk("t6_sat_b", bus_b.StallCount, 15);
        chk("t6_cnt_a", bus_a.StallCount, 20);
        step();

        // Random traffic
        repeat (500) begin
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            rd_ex = 5'($urandom_range(0, 3));
            rd_mem = 5'($urandom_range(0, 3));
            use_rs = 1'($urandom);
            use_rt = 1'($urandom);
            is_br = 1'($urandom);
            jump = ($urandom_range(0, 5) == 0);
            taken = 1'($urandom);
            regwr_ex = 1'($urandom);
            memrd_ex = ($urandom_range(0, 2) == 0);
            memrd_mem = ($urandom_range(0, 2) == 0);
            mds = ($urandom_range(0, 11) == 0);
            rst_n = ($urandom_range(0, 59) != 0);
            step();
        end
        rst_n = 1;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
